// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM states and frame/addressing constants.
package loader_pkg;

  typedef enum logic [2:0] {
    HDR_HI  = 3'd0,
    HDR_LO  = 3'd1,
    COLLECT = 3'd2,
    WRITE   = 3'd3,
    DONE    = 3'd4,
    ERROR   = 3'd5
  } state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam logic [31:0] ADDR_STEP  = 32'd4;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle counter: cleared by each accepted byte, flags expiry on the
// edge at which LIMIT idle cycles have elapsed.
module loader_timeout #(
  parameter int unsigned LIMIT = 1_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [W-1:0] count_q;

  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      count_q <= '0;
    end else if (count_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Expiry fires on the edge that would complete the LIMIT-th idle cycle.
  assign expire_o = count_i && !clear_i && (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/program_loader.sv
// Boot loader: assembles a big-endian byte stream into words, writes them to
// data memory and holds the CPU in reset until the image is complete.
module program_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rxValid,
  input  logic [7:0]  rxData,
  output logic        rxReady,
  output logic        memWrite,
  output logic [31:0] address,
  output logic [31:0] writeData,
  output logic        cpuReset,
  output logic        done,
  output logic        error
);

  state_e      state_q;
  logic [15:0] count_q;
  logic [15:0] wcount_q;
  logic [23:0] word_q;
  logic [1:0]  bidx_q;
  logic        rxReady_q;
  logic        memWrite_q;
  logic [31:0] address_q;
  logic [31:0] writeData_q;
  logic        cpuReset_q;
  logic        done_q;
  logic        error_q;

  logic        accept;
  logic        counting;
  logic        expire;
  logic [15:0] hdr_count;

  assign accept    = rxValid && rxReady_q;
  assign counting  = (state_q == HDR_LO) || (state_q == COLLECT);
  assign hdr_count = {count_q[15:8], rxData};

  loader_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (accept),
    .count_i  (counting),
    .expire_o (expire)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= HDR_HI;
      count_q     <= '0;
      wcount_q    <= '0;
      word_q      <= '0;
      bidx_q      <= '0;
      rxReady_q   <= 1'b1;
      memWrite_q  <= 1'b0;
      address_q   <= BASE_ADDR;
      writeData_q <= '0;
      cpuReset_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      case (state_q)
        HDR_HI: begin
          if (accept) begin
            count_q[15:8] <= rxData;
            state_q       <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (accept) begin
            count_q[7:0] <= rxData;
            bidx_q       <= '0;
            if (hdr_count == 16'd0) begin
              state_q    <= DONE;
              rxReady_q  <= 1'b0;
              done_q     <= 1'b1;
              cpuReset_q <= 1'b0;
            end else if ({16'd0, hdr_count} > MAX_WORDS) begin
              state_q   <= ERROR;
              rxReady_q <= 1'b0;
              error_q   <= 1'b1;
            end else begin
              state_q <= COLLECT;
            end
          end else if (expire) begin
            state_q   <= ERROR;
            rxReady_q <= 1'b0;
            error_q   <= 1'b1;
          end
        end
        COLLECT: begin
          if (accept) begin
            word_q <= {word_q[15:0], rxData};
            bidx_q <= bidx_q + 2'd1;
            if (bidx_q == 2'(WORD_BYTES - 1)) begin
              state_q     <= WRITE;
              rxReady_q   <= 1'b0;
              memWrite_q  <= 1'b1;
              writeData_q <= {word_q, rxData};
            end
          end else if (expire) begin
            state_q   <= ERROR;
            rxReady_q <= 1'b0;
            error_q   <= 1'b1;
          end
        end
        WRITE: begin
          memWrite_q <= 1'b0;
          address_q  <= address_q + ADDR_STEP;
          wcount_q   <= wcount_q + 16'd1;
          if ((wcount_q + 16'd1) == count_q) begin
            state_q    <= DONE;
            done_q     <= 1'b1;
            cpuReset_q <= 1'b0;
          end else begin
            state_q   <= COLLECT;
            rxReady_q <= 1'b1;
          end
        end
        DONE, ERROR: begin
        end
        default: begin
          state_q   <= ERROR;
          rxReady_q <= 1'b0;
          error_q   <= 1'b1;
        end
      endcase
    end
  end

  assign rxReady   = rxReady_q;
  assign memWrite  = memWrite_q;
  assign address   = address_q;
  assign writeData = writeData_q;
  assign cpuReset  = cpuReset_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as frames are
// driven and matched against memWrite strobes; a local array stands in for data_memory.
module tb_program_loader;

  localparam int unsigned TO = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rxValid = 1'b0;
  logic [7:0]  rxData = 8'h00;
  logic        rxReady;
  logic        memWrite;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        cpuReset;
  logic        done;
  logic        error;

  always #5 clock = ~clock;

  program_loader #(
    .BASE_ADDR      (32'h0000_0000),
    .MAX_WORDS      (256),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rxValid   (rxValid),
    .rxData    (rxData),
    .rxReady   (rxReady),
    .memWrite  (memWrite),
    .address   (address),
    .writeData (writeData),
    .cpuReset  (cpuReset),
    .done      (done),
    .error     (error)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          wr_count = 0;
  wr_t         sb[$];
  logic [31:0] mem [logic [31:0]];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  always @(negedge clock) begin : monitor
    wr_t e;
    if (memWrite === 1'b1) begin
      wr_count++;
      check_eq("rdy_in_write", {31'd0, rxReady}, 32'd0);
      check_eq("addr_align", {30'd0, address[1:0]}, 32'd0);
      if (sb.size() == 0) begin
        check_eq("unexpected_write", {31'd0, memWrite}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("wr_addr", address, e.addr);
        check_eq("wr_data", writeData, e.data);
      end
      mem[address] = writeData;
    end
    if (done === 1'b1) check_eq("done_vs_error", {31'd0, error}, 32'd0);
  end

  // Presents a byte and returns just after the edge that accepts it.
  task automatic send_byte(input logic [7:0] b);
    int unsigned waited = 0;
    bit          ok = 0;
    @(negedge clock);
    rxValid = 1'b1;
    rxData  = b;
    while (!ok && waited < 100) begin
      if (rxReady === 1'b1) begin
        @(posedge clock);
        ok = 1;
      end else begin
        @(posedge clock);
        @(negedge clock);
        waited++;
      end
    end
    if (!ok) check_eq("rx_accept_timeout", {31'd0, rxReady}, 32'd1);
  endtask

  task automatic idle();
    @(negedge clock);
    rxValid = 1'b0;
  endtask

  task automatic apply_reset(input logic v, input logic [7:0] d);
    @(negedge clock);
    reset   = 1'b1;
    rxValid = v;
    rxData  = d;
    repeat (2) @(negedge clock);
    reset   = 1'b0;
    rxValid = 1'b0;
  endtask

  task automatic check_reset_state(input string pfx);
    check_eq({pfx, "_rxReady"},   {31'd0, rxReady},  32'd1);
    check_eq({pfx, "_memWrite"},  {31'd0, memWrite}, 32'd0);
    check_eq({pfx, "_address"},   address,           32'h0000_0000);
    check_eq({pfx, "_writeData"}, writeData,         32'h0000_0000);
    check_eq({pfx, "_cpuReset"},  {31'd0, cpuReset}, 32'd1);
    check_eq({pfx, "_done"},      {31'd0, done},     32'd0);
    check_eq({pfx, "_error"},     {31'd0, error},    32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          w0;
    logic [31:0] words [3];
    words[0] = 32'hCAFE_0001;
    words[1] = 32'h1234_5678;
    words[2] = 32'h8000_00FF;

    // Reset state
    apply_reset(1'b0, 8'h00);
    check_reset_state("rst");

    // Two-word frame
    w0 = wr_count;
    expect_wr(32'h0, 32'h2008_0005);
    expect_wr(32'h4, 32'h0109_5020);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h01); send_byte(8'h09); send_byte(8'h50); send_byte(8'h20);
    idle();
    check_eq("t2_done_during_write", {31'd0, done}, 32'd0);
    @(negedge clock);
    check_eq("t2_done", {31'd0, done}, 32'd1);
    check_eq("t2_cpuReset", {31'd0, cpuReset}, 32'd0);
    check_eq("t2_rxReady", {31'd0, rxReady}, 32'd0);
    check_eq("t2_writes", wr_count - w0, 32'd2);

    // Zero-length frame
    apply_reset(1'b0, 8'h00);
    w0 = wr_count;
    send_byte(8'h00); send_byte(8'h00);
    idle();
    check_eq("t0_done", {31'd0, done}, 32'd1);
    check_eq("t0_cpuReset", {31'd0, cpuReset}, 32'd0);
    repeat (3) @(negedge clock);
    check_eq("t0_writes", wr_count - w0, 32'd0);

    // Oversize header (257 words)
    apply_reset(1'b0, 8'h00);
    w0 = wr_count;
    send_byte(8'h01); send_byte(8'h01);
    idle();
    check_eq("big_error", {31'd0, error}, 32'd1);
    check_eq("big_cpuReset", {31'd0, cpuReset}, 32'd1);
    check_eq("big_rxReady", {31'd0, rxReady}, 32'd0);
    check_eq("big_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clock);
    check_eq("big_writes", wr_count - w0, 32'd0);

    // Timeout after two data bytes
    apply_reset(1'b0, 8'h00);
    w0 = wr_count;
    send_byte(8'h00); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
    idle();
    repeat (TO - 1) @(negedge clock);
    check_eq("to_error_early", {31'd0, error}, 32'd0);
    @(negedge clock);
    check_eq("to_error", {31'd0, error}, 32'd1);
    check_eq("to_cpuReset", {31'd0, cpuReset}, 32'd1);
    check_eq("to_writes", wr_count - w0, 32'd0);

    // Three-word frame with rxValid held high throughout
    apply_reset(1'b0, 8'h00);
    w0 = wr_count;
    for (int i = 0; i < 3; i++) expect_wr(32'(i) * 32'd4, words[i]);
    send_byte(8'h00); send_byte(8'h03);
    for (int i = 0; i < 3; i++) begin
      for (int j = 3; j >= 0; j--) begin
        logic [31:0] w;
        w = words[i];
        send_byte(w[j*8 +: 8]);
      end
    end
    idle();
    @(negedge clock);
    check_eq("t3_done", {31'd0, done}, 32'd1);
    check_eq("t3_writes", wr_count - w0, 32'd3);
    for (int i = 0; i < 3; i++) check_eq("t3_readback", mem[32'(i) * 32'd4], words[i]);

    // Reset mid-frame (with a byte offered during reset), then a fresh frame
    apply_reset(1'b0, 8'h00);
    expect_wr(32'h0, 32'h1122_3344);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    idle();
    @(negedge clock);
    check_eq("mid_addr_advanced", address, 32'h4);
    apply_reset(1'b1, 8'h00);
    check_reset_state("mid");
    w0 = wr_count;
    expect_wr(32'h0, 32'hDEAD_BEEF);
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    idle();
    @(negedge clock);
    check_eq("mid_done", {31'd0, done}, 32'd1);
    check_eq("mid_cpuReset", {31'd0, cpuReset}, 32'd0);
    check_eq("mid_writes", wr_count - w0, 32'd1);
    check_eq("mid_readback", mem[32'h0], 32'hDEAD_BEEF);

    check_eq("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
